// File: rtl/tmds_encoder.sv
// tmds_encoder: single-channel DVI/HDMI TMDS 8b/10b encoder.
// Stage 1 forms the transition-minimised word q_m plus its ones count.
// Stage 2 chooses the DC-balancing inversion and keeps the running disparity.
// Fixed two-cycle latency for both pixel data and control symbols.
// Optional feature macro: TMDS_DISPARITY_OUT_EN adds the signed 'disparity'
// output carrying the registered running disparity, aligned with tmds_out.
module tmds_encoder #(
  parameter logic [1:0] CTRL_RESET = 2'b00
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] tmds_out
`ifdef TMDS_DISPARITY_OUT_EN
  ,
  output logic signed [4:0] disparity
`endif
);

  // Number of ones in a byte.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Transition-minimising chain; bit 8 flags the XOR variant.
  function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic use_xnor);
    logic [8:0] q;
    q    = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Blanking-period control symbols.
  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      2'b11:   s = 10'b1010101011;
      default: s = 10'b1101010100;
    endcase
    return s;
  endfunction

  logic [3:0]        n1d_s;
  logic              use_xnor_s;
  logic [8:0]        q_m_s;

  logic [8:0]        q_m_r;
  logic [3:0]        n1q_r;
  logic              de_r;
  logic [1:0]        c_r;

  logic signed [4:0] n1q_s;
  logic signed [4:0] n0q_s;
  logic signed [4:0] diff_s;
  logic signed [4:0] two_q8_s;
  logic signed [4:0] two_nq8_s;
  logic [9:0]        sym_s;
  logic signed [4:0] cnt_nxt_s;

  logic [9:0]        tmds_out_r;
  logic signed [4:0] cnt_r;

  // Stage 1 combinational: choose XOR/XNOR chain from the byte's ones count.
  always_comb begin
    n1d_s      = popcount8(data_in);
    use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (data_in[0] == 1'b0));
    q_m_s      = qm_encode(data_in, use_xnor_s);
  end

  // Stage 1 register: q_m, its ones count, and the aligned de/control bits.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      q_m_r <= 9'd0;
      n1q_r <= 4'd0;
      de_r  <= 1'b0;
      c_r   <= CTRL_RESET;
    end else begin
      q_m_r <= q_m_s;
      n1q_r <= popcount8(q_m_s[7:0]);
      de_r  <= de;
      c_r   <= {c1, c0};
    end
  end

  // Stage 2 combinational: DC-balance decision and next running disparity.
  always_comb begin
    n1q_s     = {1'b0, n1q_r};
    n0q_s     = 5'sd8 - n1q_s;
    diff_s    = n1q_s - n0q_s;
    two_q8_s  = {3'b000, q_m_r[8], 1'b0};
    two_nq8_s = {3'b000, ~q_m_r[8], 1'b0};
    sym_s     = ctrl_symbol(c_r);
    cnt_nxt_s = 5'sd0;
    if (!de_r) begin
      // Blanking: control symbol, disparity restarts from zero.
      sym_s     = ctrl_symbol(c_r);
      cnt_nxt_s = 5'sd0;
    end else if ((cnt_r == 5'sd0) || (n1q_s == n0q_s)) begin
      sym_s     = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
      cnt_nxt_s = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
    end else if (((cnt_r > 5'sd0) && (n1q_s > n0q_s)) ||
                 ((cnt_r < 5'sd0) && (n0q_s > n1q_s))) begin
      sym_s     = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_nxt_s = cnt_r + two_q8_s - diff_s;
    end else begin
      sym_s     = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_nxt_s = cnt_r - two_nq8_s + diff_s;
    end
  end

  // Stage 2 register: output symbol and running disparity.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      tmds_out_r <= ctrl_symbol(CTRL_RESET);
      cnt_r      <= 5'sd0;
    end else begin
      tmds_out_r <= sym_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  assign tmds_out = tmds_out_r;
`ifdef TMDS_DISPARITY_OUT_EN
  assign disparity = cnt_r;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: table of directed vectors plus a randomized stream checked
// against a behavioural TMDS model. Disparity checks need TMDS_DISPARITY_OUT_EN.
module tb_tmds_encoder;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] tmds_out;
`ifdef TMDS_DISPARITY_OUT_EN
  logic signed [4:0] disparity;
`endif

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       de;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[11];
  logic [9:0] ctrl_lut[4];

  tmds_encoder dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .data_in   (data_in),
    .c0        (c0),
    .c1        (c1),
    .de        (de),
    .tmds_out  (tmds_out)
`ifdef TMDS_DISPARITY_OUT_EN
    ,
    .disparity (disparity)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  task automatic drive(input logic d_e, input logic [1:0] c, input logic [7:0] d);
    de      = d_e;
    {c1, c0} = c;
    data_in = d;
    @(posedge pixel_clk);
    #1;
  endtask

  // Reference: q_m bit i is the parity of d[0..i], flipped on odd i for the XNOR variant.
  task automatic model_sym(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                           output logic [9:0] sym);
    int         ones;
    int         par;
    int         n1;
    int         n0;
    logic       xn;
    logic       q8;
    logic [7:0] qm;
    if (!d_e) begin
      sym   = ctrl_lut[c];
      m_cnt = 0;
    end else begin
      ones = $countones(d);
      xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      par  = 0;
      for (int i = 0; i < 8; i++) begin
        par   = par ^ int'(d[i]);
        qm[i] = 1'(par ^ ((xn && (i % 2 == 1)) ? 1 : 0));
      end
      q8 = !xn;
      n1 = $countones(qm);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
        sym   = {~q8, q8, (q8 ? qm : ~qm)};
        m_cnt = m_cnt + (q8 ? (n1 - n0) : (n0 - n1));
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        sym   = {1'b1, q8, ~qm};
        m_cnt = m_cnt + 2 * int'(q8) + (n0 - n1);
      end else begin
        sym   = {1'b0, q8, qm};
        m_cnt = m_cnt - 2 * int'(!q8) + (n1 - n0);
      end
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] r;
    q    = s[9] ? ~s[7:0] : s[7:0];
    r    = 8'd0;
    r[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return r;
  endfunction

  // Seed the expectation queue with the symbol the reset pipeline emits first.
  task automatic prime();
    exp_t e;
    exp_q.delete();
    m_cnt = 0;
    e.sym = 10'h354;
    e.cnt = 0;
    e.de  = 1'b0;
    e.d   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic d_e, input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    model_sym(d_e, c, d, e.sym);
    e.cnt = m_cnt;
    e.de  = d_e;
    e.d   = d;
    exp_q.push_back(e);
    drive(d_e, c, d);
    e = exp_q.pop_front();
    chk("stream_sym", int'(tmds_out), int'(e.sym));
`ifdef TMDS_DISPARITY_OUT_EN
    chk("stream_cnt", int'(disparity), e.cnt);
    chk("cnt_in_range", ((disparity <= 5'sd10) && (disparity >= -5'sd10)) ? 1 : 0, 1);
`endif
    if (e.de) begin
      chk("decode", int'(decode(tmds_out)), int'(e.d));
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    de      = 1'b0;
    {c1, c0} = 2'b00;
    data_in = 8'h00;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("reset_sym", int'(tmds_out), 32'h354);
`ifdef TMDS_DISPARITY_OUT_EN
    chk("reset_cnt", int'(disparity), 0);
`endif
    @(negedge pixel_clk);
    reset = 1'b0;
  endtask

  initial begin
    ctrl_lut[0] = 10'h354;
    ctrl_lut[1] = 10'h0AB;
    ctrl_lut[2] = 10'h154;
    ctrl_lut[3] = 10'h2AB;

    vecs[0]  = '{1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[1]  = '{1'b0, 2'b01, 8'h00, 10'h0AB, 0};
    vecs[2]  = '{1'b0, 2'b10, 8'h00, 10'h154, 0};
    vecs[3]  = '{1'b0, 2'b11, 8'h00, 10'h2AB, 0};
    vecs[4]  = '{1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
    vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'h3FF, 2};
    vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[8]  = '{1'b1, 2'b00, 8'hFF, 10'h200, -8};
    vecs[9]  = '{1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[10] = '{1'b0, 2'b00, 8'h00, 10'h354, 0};

    // Directed table: each row's symbol must appear one edge after the next row is sampled.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].de, vecs[i].c, vecs[i].d);
      if (i == 0) begin
        chk("tbl_post_reset", int'(tmds_out), 32'h354);
      end else begin
        chk("tbl_sym", int'(tmds_out), int'(vecs[i-1].sym));
`ifdef TMDS_DISPARITY_OUT_EN
        chk("tbl_cnt", int'(disparity), vecs[i-1].cnt);
`endif
      end
    end

    // Mid-line reset with nonzero disparity, then no stale state after release.
    do_reset();
    prime();
    step(1'b0, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h5A);
    chk("pre_reset_sym", int'(tmds_out), 32'h100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_sym", int'(tmds_out), 32'h354);
`ifdef TMDS_DISPARITY_OUT_EN
    chk("async_reset_cnt", int'(disparity), 0);
`endif
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b0;
    prime();
    step(1'b1, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h00);
    step(1'b0, 2'b01, 8'h00);
    step(1'b0, 2'b00, 8'h00);

    // Randomized stream: 200 active pixels then 40 blanking cycles per line.
    for (int n = 0; n < 10000; n++) begin
      if ((n % 240) >= 200) begin
        step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        step(1'b1, 2'b00, 8'($urandom));
      end
    end
    step(1'b0, 2'b00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Single-channel DVI/HDMI TMDS 8b/10b encoder.
- Sits directly downstream of the video generator, with one instance per colour channel: blue carries hsync/vsync on c0/c1, and red and green tie c0/c1 low.
- Converts one 8-bit pixel colour (or 2 control bits during blanking) per pixel_clk into a DC-balanced 10-bit symbol for the serializer.
- Two-stage pipeline, fixed latency.

Parameters:
- CTRL_RESET, 2'b00, control pair driven out of reset (selects reset symbol).

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  pixel colour value (red, green or blue byte).
- c0  in  1  control bit 0 (hsync on blue channel).
- c1  in  1  control bit 1 (vsync on blue channel).
- de  in  1  data enable: 1 = active video, 0 = blanking.
- tmds_out  out  10  encoded TMDS symbol, bit 0 transmitted first.

Behaviour:
- Clocking and reset: one clock (pixel_clk); reset is asynchronous and active-high, as already decided.
- Reset state:
  - tmds_out = control symbol for CTRL_RESET (default 10'b1101010100).
  - Running disparity cnt = 0; stage-1 de = 0; stage-1 c = CTRL_RESET.
- Reset asserted mid-stream clears all pipeline state immediately. The first symbol after release is a function of the inputs sampled after release.
- Latency: inputs sampled at edge k appear on tmds_out after edge k+1, i.e. 2 cycles, identical for data and control. A de transition shifts the output by exactly the same 2 cycles.
- Stage 1 (register):
  - N1d = popcount(data_in).
  - If N1d > 4, or (N1d == 4 and data_in[0] == 0): XNOR path. q_m[0] = d[0]; q_m[i] = ~(q_m[i-1] ^ d[i]); q_m[8] = 0.
  - Else: XOR path. q_m[i] = q_m[i-1] ^ d[i]; q_m[8] = 1.
  - Register q_m[8:0], N1q = popcount(q_m[7:0]) (4 bits), N0q = 8 - N1q, de, c1/c0.
- Stage 2 (register tmds_out, cnt):
  - de = 0:
    - tmds_out by {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
    - cnt <= 0.
  - de = 1, cnt == 0 or N1q == N0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt <= cnt + (q_m[8] ? N1q - N0q : N0q - N1q).
  - de = 1, (cnt > 0 and N1q > N0q) or (cnt < 0 and N0q > N1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt <= cnt + 2*q_m[8] + (N0q - N1q).
  - de = 1, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt <= cnt - 2*(~q_m[8]) + (N1q - N0q).
- Arithmetic:
  - cnt is 5-bit two's complement (range -16..+15).
  - All disparity arithmetic is done in signed 5-bit; N1q/N0q are zero-extended before subtraction.
  - A legal stream never exceeds +/-10; no saturation logic.
- Boundary: first active pixel after blanking always uses the cnt == 0 branch, because blanking forces cnt = 0.
- No backpressure, no handshake; one symbol per cycle unconditionally.

Optional Feature:
- Macro: TMDS_DISPARITY_OUT_EN.
- Defined:
  - Adds output port disparity (5, signed) carrying the registered cnt, aligned with tmds_out.
  - Reset value 0.
  - For bench/ILA observation only.
- Undefined: port absent; no other behavioural change.

Test Plan:
- Reset held, then released with de=0, c=00 -> tmds_out = 10'b1101010100 during reset and 2 cycles after release.
- de=0, {c1,c0} stepped 00, 01, 10, 11 on consecutive cycles -> tmds_out shows 0x354, 0x0AB, 0x154, 0x2AB, each appearing exactly 2 cycles after its input.
- Blanking then de=1, data_in=0x00 for 2 pixels -> tmds_out 0x100 (cnt -8), then 0x3FF (cnt +2).
- Blanking then de=1, data_in=0xFF -> tmds_out 0x200, cnt -8; the following blanking cycle restores cnt = 0.
- Random 10k-pixel data stream with periodic blanking, checked against a reference model -> bit-exact tmds_out; cnt stays within +/-10; every symbol decodes back to the input byte.
- Reset asserted mid-active-line with cnt != 0 -> tmds_out = 0x354 and cnt = 0 immediately (asynchronous); no stale symbol emitted after release.
